simon_key_sched_ctrl: RTL and testbench

SIMON_KEY_SCHED_CTRL -- requirements
Module: simon_key_sched_ctrl

---
 rtl/simon_key_sched_ctrl.sv | 165 ++++++++++++++++
 tb/tb_simon_key_sched_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/simon_key_sched_ctrl.sv
// SIMON key-schedule controller: streams T round keys over a valid/ready handshake.
// Optional build macro KS_ZEROIZE_EN clears the key window in the DONE cycle.
`ifndef N
`define N 16
`endif
`ifndef M
`define M 4
`endif

module simon_key_sched_ctrl #(
  parameter int n = `N,
  parameter int m = `M
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [n*m-1:0] key_in,
  output logic [n-1:0]   rk_out,
  output logic [6:0]     rk_idx,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic           busy,
  output logic           done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic int rounds(input int nn, input int mm);
    int r;
    r = 0;
    case (nn)
      16:      r = (mm == 4) ? 32 : 0;
      24:      r = (mm == 3 || mm == 4) ? 36 : 0;
      32:      r = (mm == 3) ? 42 : ((mm == 4) ? 44 : 0);
      48:      r = (mm == 2) ? 52 : ((mm == 3) ? 54 : 0);
      64:      r = (mm == 2) ? 68 : ((mm == 3) ? 69 : ((mm == 4) ? 72 : 0));
      default: r = 0;
    endcase
    return r;
  endfunction

  // Literals are written with z[0] as the leftmost (most significant) bit.
  function automatic logic [61:0] z_seq(input int nn, input int mm);
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    case (nn)
      24:      z = (mm == 3) ? 62'b11111010001001010110000111001101111101000100101011000011100110
                             : 62'b10001110111110010011000010110101000111011111001001100001011010;
      32:      z = (mm == 3) ? 62'b10101111011100000011010010011000101000010001111110010110110011
                             : 62'b11011011101011000110010111100000010010001010011100110100001111;
      48:      z = (mm == 2) ? 62'b10101111011100000011010010011000101000010001111110010110110011
                             : 62'b11011011101011000110010111100000010010001010011100110100001111;
      64:      z = (mm == 2) ? 62'b10101111011100000011010010011000101000010001111110010110110011
                             : ((mm == 3) ? 62'b11011011101011000110010111100000010010001010011100110100001111
                                          : 62'b11010001111001101011011000100000010111000011001010010011101111);
      default: z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    endcase
    return z;
  endfunction

  localparam int          T    = rounds(n, m);
  localparam logic [61:0] ZSEQ = z_seq(n, m);

  if (T == 0) begin : g_bad_params
    $error("simon_key_sched_ctrl: unsupported (n,m) pair");
  end

  function automatic logic [n-1:0] ror(input logic [n-1:0] x, input int s);
    return (x >> s) | (x << (n - s));
  endfunction

  // Words below m come straight from the master key; later ones use the SIMON recurrence.
  function automatic logic [n-1:0] key_expansion(input logic [n*m-1:0] win, input logic [6:0] idx);
    logic [n-1:0] tmp;
    int           zi;
    if (int'(idx) < m) begin
      return win[int'(idx)*n +: n];
    end else begin
      zi  = (int'(idx) - m) % 62;
      tmp = ror(win[n*m-1 -: n], 3);
      if (m == 4) tmp = tmp ^ win[2*n-1:n];
      else        tmp = tmp;
      tmp = tmp ^ ror(tmp, 1);
      return ~win[n-1:0] ^ tmp ^ n'(2'd3) ^ {{(n-1){1'b0}}, ZSEQ[61-zi]};
    end
  endfunction

  logic [1:0]     state_q, state_d;
  logic [6:0]     i_q, i_d;
  logic [n*m-1:0] window_q, window_d;
  logic [n-1:0]   kexp_s;
  logic           hs_s;

  assign kexp_s   = key_expansion(window_q, i_q);
  assign rk_valid = (state_q == EMIT);
  assign rk_out   = rk_valid ? kexp_s : '0;
  assign rk_idx   = rk_valid ? i_q : 7'd0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hs_s     = rk_valid & rk_ready;

  // Next-state, round counter and key window update.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    window_d = window_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          window_d = key_in;
          i_d      = 7'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = EMIT;
        i_d     = 7'd0;
      end
      EMIT: begin
        if (hs_s) begin
          i_d = i_q + 7'd1;
          if (int'(i_q) >= m) window_d = {kexp_s, window_q[n*m-1:n]};
          else                window_d = window_q;
          if (i_q == 7'(T - 1)) state_d = DONE;
          else                  state_d = EMIT;
        end else begin
          state_d = EMIT;
        end
      end
      DONE: begin
        state_d = IDLE;
        i_d     = 7'd0;
`ifdef KS_ZEROIZE_EN
        window_d = '0;
`else
        window_d = window_q;
`endif
      end
      default: begin
        state_d  = IDLE;
        i_d      = 7'd0;
        window_d = '0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= 7'd0;
      window_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      window_q <= window_d;
    end
  end

endmodule

// File: tb/tb_simon_key_sched_ctrl.sv
// Directed self-checking bench for simon_key_sched_ctrl at n=16, m=4 (Simon32/64).
`timescale 1ns/1ps
module tb_simon_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] key_in;
  logic [15:0] rk_out;
  logic [6:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] k [0:31];
  logic [61:0] z0;

  simon_key_sched_ctrl #(.n(16), .m(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] r16(input logic [15:0] x, input int s);
    return (x >> s) | (x << (16 - s));
  endfunction

  initial begin
    int cnt;
    int hs;
    logic [15:0] prev_out;
    logic [6:0]  prev_idx;
    logic        prev_stall;

    // Reference schedule: k[i+4] = c ^ z ^ k[i] ^ S^-3 k[i+3] ^ S^-4 k[i+3] ^ k[i+1] ^ S^-1 k[i+1]
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    k[0] = 16'h0100; k[1] = 16'h0908; k[2] = 16'h1110; k[3] = 16'h1918;
    for (int j = 0; j < 28; j++) begin
      k[j+4] = 16'hFFFC ^ {15'd0, z0[61-j]} ^ k[j] ^ r16(k[j+3], 3) ^ r16(k[j+3], 4)
               ^ k[j+1] ^ r16(k[j+1], 1);
    end

    rst_n = 1'b0; start = 1'b0; key_in = 64'h1918_1110_0908_0100; rk_ready = 1'b1;
    #12;
    chk("rst_valid", {63'd0, rk_valid}, 64'd0);
    chk("rst_busy",  {63'd0, busy},     64'd0);
    chk("rst_done",  {63'd0, done},     64'd0);
    chk("rst_out",   {48'd0, rk_out},   64'd0);
    chk("rst_idx",   {57'd0, rk_idx},   64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Full schedule with rk_ready held high.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_valid", {63'd0, rk_valid}, 64'd0);
    chk("load_busy",  {63'd0, busy},     64'd1);
    step();
    chk("hand_k0", {48'd0, rk_out}, 64'h0100);
    chk("hand_k4", {48'd0, k[4]},  64'h71C3);
    chk("hand_k5", {48'd0, k[5]},  64'hB649);
    chk("hand_k6", {48'd0, k[6]},  64'h56D4);
    chk("hand_k7", {48'd0, k[7]},  64'hE070);
    hs = 0;
    for (int j = 0; j < 32; j++) begin
      chk("full_valid", {63'd0, rk_valid}, 64'd1);
      chk("full_idx",   {57'd0, rk_idx},   64'(j));
      chk("full_out",   {48'd0, rk_out},   {48'd0, k[j]});
      chk("full_done_low", {63'd0, done},  64'd0);
      if (rk_valid && rk_ready) hs++;
      step();
    end
    chk("handshakes", 64'(hs), 64'd32);
    chk("done_pulse", {63'd0, done},     64'd1);
    chk("done_valid", {63'd0, rk_valid}, 64'd0);
    chk("done_out",   {48'd0, rk_out},   64'd0);
    step();
    chk("post_done",  {63'd0, done}, 64'd0);
    chk("post_busy",  {63'd0, busy}, 64'd0);
`ifdef KS_ZEROIZE_EN
    chk("window_zero", dut.window_q, 64'd0);
`else
    chk("window_hold", dut.window_q, {k[31], k[30], k[29], k[28]});
`endif

    // Stalled consumer: rk_ready pattern 1,0,0,1 repeating.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cnt = 0;
    prev_stall = 1'b0;
    prev_out = 16'd0;
    prev_idx = 7'd0;
    for (int c = 0; c < 64 && cnt < 8; c++) begin
      rk_ready = ((c % 4) == 0) || ((c % 4) == 3);
      chk("stall_valid", {63'd0, rk_valid}, 64'd1);
      chk("stall_idx",   {57'd0, rk_idx},   64'(cnt));
      chk("stall_out",   {48'd0, rk_out},   {48'd0, k[cnt]});
      if (prev_stall) begin
        chk("stall_hold_out", {48'd0, rk_out}, {48'd0, prev_out});
        chk("stall_hold_idx", {57'd0, rk_idx}, {57'd0, prev_idx});
      end
      prev_stall = !rk_ready;
      prev_out = rk_out;
      prev_idx = rk_idx;
      if (rk_valid && rk_ready) cnt++;
      step();
    end
    chk("stall_count", 64'(cnt), 64'd8);

    // Advance to idx 10, then reset mid-schedule.
    rk_ready = 1'b1;
    for (int c = 0; c < 20 && rk_idx != 7'd10; c++) step();
    chk("pre_rst_idx", {57'd0, rk_idx}, 64'd10);
    chk("pre_rst_out", {48'd0, rk_out}, {48'd0, k[10]});
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, rk_valid}, 64'd0);
    chk("midrst_idx",   {57'd0, rk_idx},   64'd0);
    chk("midrst_out",   {48'd0, rk_out},   64'd0);
    chk("midrst_busy",  {63'd0, busy},     64'd0);
    chk("midrst_done",  {63'd0, done},     64'd0);
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();

    // Restarted schedule; a start with a foreign key at idx 5 must be ignored.
    for (int j = 0; j < 32; j++) begin
      if (j == 5) begin
        start  = 1'b1;
        key_in = 64'hDEAD_BEEF_CAFE_F00D;
      end else begin
        start = 1'b0;
      end
      chk("restart_idx", {57'd0, rk_idx}, 64'(j));
      chk("restart_out", {48'd0, rk_out}, {48'd0, k[j]});
      step();
    end
    start = 1'b0;
    chk("restart_done", {63'd0, done}, 64'd1);
    step();
    chk("restart_idle", {63'd0, busy}, 64'd0);
    step();
    chk("stay_idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
